// File: rtl/dmem_access_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//
// MEM-stage data-memory controller for the pipelined RV32 core. It turns each
// load or store from the EX/MEM register into one handshaked bus transaction,
// generates byte enables and lane-replicated store data, and returns the
// sign/zero-extended load result. While a transaction is in flight o_stall
// freezes the IF/ID/EX/MEM pipeline registers.
//
// Ports
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_mem_read_MEM      load in MEM stage
//   i_mem_write_MEM     store in MEM stage (wins if both strobes are set)
//   i_funct3_MEM        access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   i_alu_result_MEM    byte address
//   i_dataB_MEM         unshifted store data
//   o_bus_valid/we/addr/be/wdata   request channel (word address, [1:0]=00)
//   i_bus_ready         request accepted
//   i_bus_rvalid/rdata  read response
//   o_stall             pipeline freeze
//   o_load_data_MEM     extended load result, valid in DONE, held otherwise
//   o_misaligned        misaligned access detected (no bus activity)
//   o_bus_err           transaction aborted by timeout
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
  parameter int TIMEOUT = 16,  // max cycles in REQ+WAIT_RSP, >= 2
  parameter int CNT_W   = 5    // must be able to hold TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_read_MEM,
  input  logic        i_mem_write_MEM,
  input  logic [2:0]  i_funct3_MEM,
  input  logic [31:0] i_alu_result_MEM,
  input  logic [31:0] i_dataB_MEM,
  output logic        o_bus_valid,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ready,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata,
  output logic        o_stall,
  output logic [31:0] o_load_data_MEM,
  output logic        o_misaligned,
  output logic        o_bus_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RSP,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [29:0]       addr_q,      addr_d;      // word address
  logic [1:0]        off_q,       off_d;       // byte offset within the word
  logic [3:0]        be_q,        be_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic              we_q,        we_d;
  logic [2:0]        funct3_q,    funct3_d;
  logic [31:0]       load_data_q, load_data_d;

  logic              access;
  logic              misaligned;
  logic [3:0]        be_new;
  logic [31:0]       wdata_new;

  // Pick the addressed byte/half out of the response word and extend it.
  // funct3 values other than B/H/BU/HU return the whole word.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  extract_load = {{24{b[7]}}, b};
      3'b100:  extract_load = {24'd0, b};
      3'b001:  extract_load = {{16{h[15]}}, h};
      3'b101:  extract_load = {16'd0, h};
      default: extract_load = word;
    endcase
  endfunction

  // Decode of the incoming access; only consumed in IDLE. funct3[1:0]
  // selects the size, so undefined codes (011, 110, 111) behave as W.
  always_comb begin
    access = i_mem_read_MEM | i_mem_write_MEM;
    case (i_funct3_MEM[1:0])
      2'b00: begin
        misaligned = 1'b0;
        be_new     = 4'b0001 << i_alu_result_MEM[1:0];
        wdata_new  = {4{i_dataB_MEM[7:0]}};
      end
      2'b01: begin
        misaligned = i_alu_result_MEM[0];
        be_new     = 4'b0011 << i_alu_result_MEM[1:0];
        wdata_new  = {2{i_dataB_MEM[15:0]}};
      end
      default: begin
        misaligned = |i_alu_result_MEM[1:0];
        be_new     = 4'b1111;
        wdata_new  = i_dataB_MEM;
      end
    endcase
  end

  // Next-state and output logic.
  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    off_d        = off_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    load_data_d  = load_data_q;
    o_stall      = 1'b0;
    o_misaligned = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (misaligned) begin
            o_misaligned = 1'b1;
          end else begin
            // Stall must rise in this very cycle, before the pipeline moves.
            o_stall  = 1'b1;
            addr_d   = i_alu_result_MEM[31:2];
            off_d    = i_alu_result_MEM[1:0];
            be_d     = be_new;
            wdata_d  = wdata_new;
            we_d     = i_mem_write_MEM;
            funct3_d = i_funct3_MEM;
            cnt_d    = '0;
            state_d  = S_REQ;
          end
        end
      end

      S_REQ: begin
        o_stall = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (i_bus_ready) begin
          if (we_q) begin
            load_data_d = '0;  // a completed store reports zero load data
            state_d     = S_DONE;
          end else begin
            state_d = S_WAIT_RSP;
          end
        end else if (cnt_q == CNT_LAST) begin
          load_data_d = '0;
          state_d     = S_ERR;
        end
      end

      S_WAIT_RSP: begin
        o_stall = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (i_bus_rvalid) begin
          load_data_d = extract_load(i_bus_rdata, funct3_q, off_q);
          state_d     = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          load_data_d = '0;
          state_d     = S_ERR;
        end
      end

      // DONE and ERR release the pipeline for one cycle; strobes are not
      // sampled here, so the next instruction is first seen in IDLE.
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      off_q       <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      off_q       <= off_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      load_data_q <= load_data_d;
    end
  end

  // Request channel comes straight from registers, so it is glitch-free and
  // stable for the whole REQ phase.
  assign o_bus_valid     = (state_q == S_REQ);
  assign o_bus_we        = we_q;
  assign o_bus_addr      = {addr_q, 2'b00};
  assign o_bus_be        = be_q;
  assign o_bus_wdata     = wdata_q;
  assign o_bus_err       = (state_q == S_ERR);
  assign o_load_data_MEM = load_data_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
`timescale 1ns/1ps
module tb_dmem_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, data_b;
  logic        bus_ready, bus_rvalid;
  logic [31:0] bus_rdata;

  // Main instance (default TIMEOUT)
  logic        bus_valid, bus_we, stall, misaligned, bus_err;
  logic [31:0] bus_addr, bus_wdata, load_data;
  logic [3:0]  bus_be;

  // Short-timeout instance, shares all inputs
  logic        t_valid, t_we, t_stall, t_mis, t_err;
  logic [31:0] t_addr, t_wdata, t_load;
  logic [3:0]  t_be;

  int checks = 0;
  int errors = 0;

  dmem_access_ctrl dut (
    .i_clk(clk), .i_rst(rst),
    .i_mem_read_MEM(mem_read), .i_mem_write_MEM(mem_write),
    .i_funct3_MEM(funct3), .i_alu_result_MEM(addr), .i_dataB_MEM(data_b),
    .o_bus_valid(bus_valid), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
    .o_bus_be(bus_be), .o_bus_wdata(bus_wdata),
    .i_bus_ready(bus_ready), .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata),
    .o_stall(stall), .o_load_data_MEM(load_data),
    .o_misaligned(misaligned), .o_bus_err(bus_err)
  );

  dmem_access_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut_to (
    .i_clk(clk), .i_rst(rst),
    .i_mem_read_MEM(mem_read), .i_mem_write_MEM(mem_write),
    .i_funct3_MEM(funct3), .i_alu_result_MEM(addr), .i_dataB_MEM(data_b),
    .o_bus_valid(t_valid), .o_bus_we(t_we), .o_bus_addr(t_addr),
    .o_bus_be(t_be), .o_bus_wdata(t_wdata),
    .i_bus_ready(bus_ready), .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata),
    .o_stall(t_stall), .o_load_data_MEM(t_load),
    .o_misaligned(t_mis), .o_bus_err(t_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic int m_size(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
    return (a % 32'(m_size(f3))) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    int n   = m_size(f3);
    int off = int'(a % 32'd4);
    int v   = ((1 << n) - 1) << off;
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int n = m_size(f3);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rd);
    int n   = m_size(f3);
    int off = int'(a % 32'd4);
    longint v;
    if (n == 4) return rd;
    v = longint'(rd >> (8 * off)) & ((64'sd1 << (8 * n)) - 1);
    if (f3 < 3'd4 && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
    return v[31:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One access with ready after rd extra REQ cycles and rvalid after rv
  // extra WAIT_RSP cycles. Checks every cycle against the given expectation.
  task automatic run_txn(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rdata,
                         input int rd, input int rv, input logic noise,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_load, input logic exp_mis,
                         output int n_stall);
    logic [31:0] r;
    n_stall = 0;
    @(posedge clk); #1;
    mem_read = ~wr; mem_write = wr; funct3 = f3; addr = a; data_b = d;
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    if (stall) n_stall++;
    check("idle_misaligned", misaligned, exp_mis);
    check("idle_valid", bus_valid, 0);
    if (exp_mis) begin
      check("mis_stall", stall, 0);
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      check("mis_pulse_end", misaligned, 0);
      check("mis_no_valid", bus_valid, 0);
      check("mis_no_stall", stall, 0);
      return;
    end
    check("idle_stall", stall, 1);
    for (int k = 0; k <= rd; k++) begin
      @(posedge clk); #1;
      bus_ready  = (k == rd);
      bus_rvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      r = $urandom; bus_rdata = r;
      @(negedge clk);
      if (stall) n_stall++;
      check("req_valid", bus_valid, 1);
      check("req_we", bus_we, wr);
      check("req_addr", bus_addr, a & 32'hFFFF_FFFC);
      check("req_be", bus_be, exp_be);
      if (wr) check("req_wdata", bus_wdata, exp_wdata);
      check("req_stall", stall, 1);
    end
    if (!wr) begin
      for (int k = 0; k <= rv; k++) begin
        @(posedge clk); #1;
        bus_ready  = 1'b0;
        bus_rvalid = (k == rv);
        r = $urandom;
        bus_rdata  = (k == rv) ? rdata : r;
        @(negedge clk);
        if (stall) n_stall++;
        check("wait_valid", bus_valid, 0);
        check("wait_stall", stall, 1);
      end
    end
    @(posedge clk); #1;
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    r = $urandom; bus_rdata = r;
    @(negedge clk);
    if (stall) n_stall++;
    check("done_stall", stall, 0);
    check("done_valid", bus_valid, 0);
    check("done_load", load_data, exp_load);
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check("hold_load", load_data, exp_load);
    check("hold_stall", stall, 0);
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load;
    logic        mis;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    logic        wr, mis;
    logic [2:0]  f3;
    logic [31:0] a, d, rdat;
    logic [2:0]  ld_codes [8];

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0; addr = '0; data_b = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;

    //              wr    f3      addr         dataB         rdata         be       wdata         load          mis
    vecs[0]  = '{1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        4'b1111, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        4'b1000, 32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[2]  = '{1'b0, 3'b000, 32'h202, 32'h0,        32'h0080FF00, 4'b0100, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[3]  = '{1'b0, 3'b100, 32'h202, 32'h0,        32'h0080FF00, 4'b0100, 32'h0,        32'h00000080, 1'b0};
    vecs[4]  = '{1'b0, 3'b101, 32'h202, 32'h0,        32'h0080FF00, 4'b1100, 32'h0,        32'h00000080, 1'b0};
    vecs[5]  = '{1'b0, 3'b001, 32'h200, 32'h0,        32'h0080FF00, 4'b0011, 32'h0,        32'hFFFFFF00, 1'b0};
    vecs[6]  = '{1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[7]  = '{1'b0, 3'b001, 32'h201, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[8]  = '{1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0,        4'b1100, 32'hABCDABCD, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 3'b010, 32'h300, 32'h0,        32'h89ABCDEF, 4'b1111, 32'h0,        32'h89ABCDEF, 1'b0};
    vecs[10] = '{1'b0, 3'b011, 32'h304, 32'h0,        32'h80000001, 4'b1111, 32'h0,        32'h80000001, 1'b0};
    vecs[11] = '{1'b1, 3'b010, 32'h102, 32'h11111111, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[12] = '{1'b0, 3'b000, 32'h201, 32'h0,        32'h00007F00, 4'b0010, 32'h0,        32'h0000007F, 1'b0};
    vecs[13] = '{1'b1, 3'b010, 32'h104, 32'h0BADF00D, 32'h0,        4'b1111, 32'h0BADF00D, 32'h0,        1'b0};

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_valid", bus_valid, 0);
    check("rst_we", bus_we, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_be", bus_be, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_load", load_data, 0);
    check("rst_mis", misaligned, 0);
    check("rst_err", bus_err, 0);
    check("rst_stall", stall, 0);

    // Directed table
    foreach (vecs[i])
      run_txn(vecs[i].wr, vecs[i].f3, vecs[i].a, vecs[i].d, vecs[i].rdata, 0, 0, 1'b0,
              vecs[i].be, vecs[i].wdata, vecs[i].load, vecs[i].mis, n);

    // Store with earliest ready: exactly 2 stall cycles
    run_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0,
            4'b1111, 32'hDEADBEEF, 32'h0, 1'b0, n);
    check("sw_stall_cycles", n, 2);

    // Load, ready 3 cycles late, rvalid 2 more late, rvalid noise in REQ
    run_txn(1'b0, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, 3, 2, 1'b1,
            4'b1111, 32'h0, 32'hCAFEF00D, 1'b0, n);
    check("lw_delayed_stall_cycles", n, 8);

    // Reset while waiting for the response, then a stray rvalid
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h600;
    @(posedge clk); #1;            // REQ
    bus_ready = 1'b1;
    @(posedge clk); #1;            // WAIT_RSP
    bus_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("pre_rst_stall", stall, 1);
    @(posedge clk); #1;
    rst = 1'b0; mem_read = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h55AA55AA;
    @(negedge clk);
    check("rstw_valid", bus_valid, 0);
    check("rstw_stall", stall, 0);
    check("rstw_addr", bus_addr, 0);
    check("rstw_be", bus_be, 0);
    check("rstw_load", load_data, 0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    check("stray_rvalid_load", load_data, 0);
    check("stray_rvalid_stall", stall, 0);
    check("stray_rvalid_valid", bus_valid, 0);
    check("stray_rvalid_err", bus_err, 0);

    // Randomized accesses against the reference model
    ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    for (int t = 0; t < 200; t++) begin
      wr   = 1'($urandom_range(0, 1));
      f3   = wr ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 7)];
      a    = $urandom;
      d    = $urandom;
      rdat = $urandom;
      mis  = m_mis(f3, a);
      run_txn(wr, f3, a, d, rdat, $urandom_range(0, 4), $urandom_range(0, 4), 1'b1,
              mis ? 4'b0000 : m_be(f3, a), m_wdata(f3, d),
              wr ? 32'h0 : m_load(f3, a, rdat), mis, n);
    end

    // Timeout on the TIMEOUT=4 instance: give it a nonzero load first
    do_reset();
    run_txn(1'b0, 3'b010, 32'h500, 32'h0, 32'h12345678, 0, 0, 1'b0,
            4'b1111, 32'h0, 32'h12345678, 1'b0, n);
    check("to_prior_load", t_load, 32'h12345678);
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h504; bus_ready = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    check("to_idle_stall", t_stall, 1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("to_req_valid", t_valid, 1);
      check("to_req_err", t_err, 0);
    end
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(negedge clk);
    check("to_err", t_err, 1);
    check("to_err_stall", t_stall, 0);
    check("to_err_valid", t_valid, 0);
    check("to_err_load", t_load, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("to_err_pulse_end", t_err, 0);
    check("to_after_valid", t_valid, 0);
    check("to_after_load", t_load, 0);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
